coproc_ctrl_fsm: RTL and testbench

//  Sequencer between the instruction decode stage and the coprocessor resources
//  (matrix element memory, matrix ALU). It accepts one decoded instruction at a

---
 rtl/coproc_ctrl_pkg.sv | 51 +++++
 rtl/coproc_ctrl_timer.sv | 29 ++
 rtl/coproc_ctrl_fsm.sv | 176 +++++++++++++++++
 tb/tb_coproc_ctrl_fsm.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/coproc_ctrl_pkg.sv
// Shared types and constants for the coprocessor control sequencer:
// data/address widths, opcode values, opcode classes and FSM states.
package coproc_ctrl_pkg;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int OP_W   = 4;

  typedef enum logic [OP_W-1:0] {
    OP_NOP   = 4'd0,
    OP_LOAD  = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_MUL   = 4'd4,
    OP_AND   = 4'd5,
    OP_OR    = 4'd6,
    OP_XOR   = 4'd7,
    OP_STORE = 4'd8
  } opcode_e;

  typedef enum logic [1:0] {
    CLS_NOP,
    CLS_LOAD,
    CLS_ALU,
    CLS_STORE
  } op_class_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_RD,
    ST_RWAIT,
    ST_RHOLD,
    ST_ASTART,
    ST_AWAIT,
    ST_DONE
  } state_e;

  // Any opcode with bit 3 set is a STORE; 2..7 are ALU operations.
  function automatic op_class_e op_class(input logic [OP_W-1:0] op);
    if (op[3])
      return CLS_STORE;
    else if (op == OP_NOP)
      return CLS_NOP;
    else if (op == OP_LOAD)
      return CLS_LOAD;
    else
      return CLS_ALU;
  endfunction

endpackage

// File: rtl/coproc_ctrl_timer.sv
// Loadable up-counter with a terminal-count flag. The sequencer shares one
// instance between the memory read-latency wait and the ALU watchdog.
module coproc_ctrl_timer #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             en,
  input  logic [CNT_W-1:0] limit,
  output logic             tc
);

  logic [CNT_W-1:0] cnt;

  // Count register: load has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst_n)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (en)
      cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == limit);

endmodule

// File: rtl/coproc_ctrl_fsm.sv
// Coprocessor control sequencer: accepts one decoded instruction at a time
// and drives memory read/write or ALU start/done handshakes, returning LOAD
// results and pulsing done when each instruction retires.
// Optional build macro CTRL_TIMEOUT_EN enables the ALU watchdog and sticky err.
module coproc_ctrl_fsm
  import coproc_ctrl_pkg::*;
#(
  parameter int MEM_RD_LAT     = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  logic [OP_W-1:0]   dec_opcode,
  input  logic [ADDR_W-1:0] dec_adrs,
  input  logic [DATA_W-1:0] dec_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [OP_W-1:0]   alu_op,
  output logic              alu_start,
  input  logic              alu_done,
  output logic              result_valid,
  output logic [DATA_W-1:0] result_data,
  input  logic              result_ready,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              err_clr
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > MEM_RD_LAT) ? TIMEOUT_CYCLES : MEM_RD_LAT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] RD_LIM = CNT_W'(MEM_RD_LAT - 1);

  state_e            state_q, state_d;
  logic [OP_W-1:0]   op_q;
  logic [ADDR_W-1:0] adrs_q;
  logic [DATA_W-1:0] data_q;
  logic [DATA_W-1:0] result_q;
  logic              err_q;
  logic              accept;
  logic              tmr_load, tmr_en, tmr_tc;
  logic [CNT_W-1:0]  tmr_limit;
  logic              wd_expire;

  assign accept = instr_valid && (state_q == ST_IDLE);

  // The timer restarts from zero on entry to RWAIT (loaded in RD) and on
  // entry to AWAIT (loaded in ASTART).
  assign tmr_load = (state_q == ST_RD) || (state_q == ST_ASTART);

`ifdef CTRL_TIMEOUT_EN
  localparam logic [CNT_W-1:0] WD_LIM = CNT_W'(TIMEOUT_CYCLES - 1);

  assign tmr_en    = (state_q == ST_RWAIT) || (state_q == ST_AWAIT);
  assign tmr_limit = (state_q == ST_AWAIT) ? WD_LIM : RD_LIM;
  assign wd_expire = (state_q == ST_AWAIT) && tmr_tc && !alu_done;

  // Sticky watchdog error; a clear request wins over a same-cycle expiry.
  always_ff @(posedge clk) begin
    if (!rst_n)
      err_q <= 1'b0;
    else if (err_clr)
      err_q <= 1'b0;
    else if (wd_expire)
      err_q <= 1'b1;
  end
`else
  logic unused_err_clr;

  assign tmr_en         = (state_q == ST_RWAIT);
  assign tmr_limit      = RD_LIM;
  assign wd_expire      = 1'b0;
  assign err_q          = 1'b0;
  assign unused_err_clr = err_clr;
`endif

  coproc_ctrl_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (tmr_load),
    .load_val ('0),
    .en       (tmr_en),
    .limit    (tmr_limit),
    .tc       (tmr_tc)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n)
      state_q <= ST_IDLE;
    else
      state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (instr_valid) begin
          unique case (op_class(dec_opcode))
            CLS_NOP:   state_d = ST_DONE;
            CLS_LOAD:  state_d = ST_RD;
            CLS_ALU:   state_d = ST_ASTART;
            CLS_STORE: state_d = ST_WR;
            default:   state_d = ST_IDLE;
          endcase
        end
      end
      ST_WR:     state_d = ST_DONE;
      ST_RD:     state_d = ST_RWAIT;
      ST_RWAIT:  if (tmr_tc) state_d = ST_RHOLD;
      ST_RHOLD:  if (result_ready) state_d = ST_DONE;
      ST_ASTART: state_d = ST_AWAIT;
      ST_AWAIT:  if (alu_done || wd_expire) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Output decode: all strobes are single-state Moore outputs.
  always_comb begin
    instr_ready  = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    mem_we       = 1'b0;
    mem_re       = 1'b0;
    alu_start    = 1'b0;
    result_valid = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        instr_ready = 1'b1;
        busy        = 1'b0;
      end
      ST_WR:     mem_we       = 1'b1;
      ST_RD:     mem_re       = 1'b1;
      ST_RHOLD:  result_valid = 1'b1;
      ST_ASTART: alu_start    = 1'b1;
      ST_DONE:   done         = 1'b1;
      default:   ;
    endcase
  end

  // Instruction fields latched on accept; LOAD data captured on the last
  // latency cycle. Cleared by reset so a reset drops any pending result.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q     <= '0;
      adrs_q   <= '0;
      data_q   <= '0;
      result_q <= '0;
    end else begin
      if (accept) begin
        op_q   <= dec_opcode;
        adrs_q <= dec_adrs;
        data_q <= dec_data;
      end
      if ((state_q == ST_RWAIT) && tmr_tc)
        result_q <= mem_rdata;
    end
  end

  assign mem_addr    = adrs_q;
  assign mem_wdata   = data_q;
  assign alu_op      = op_q;
  assign result_data = result_q;
  assign err         = err_q;

endmodule

// File: tb/tb_coproc_ctrl_fsm.sv
// Directed, table-driven bench for coproc_ctrl_fsm with a latency-accurate
// memory model. Watchdog sequences are built when CTRL_TIMEOUT_EN is defined.
module tb_coproc_ctrl_fsm;

  localparam int LAT = 2;
`ifdef CTRL_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  localparam int K_NOP   = 0;
  localparam int K_LOAD  = 1;
  localparam int K_ALU   = 2;
  localparam int K_STORE = 3;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic        instr_ready;
  logic [3:0]  dec_opcode;
  logic [7:0]  dec_adrs;
  logic [15:0] dec_data;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_we;
  logic        mem_re;
  logic [15:0] mem_rdata;
  logic [3:0]  alu_op;
  logic        alu_start;
  logic        alu_done;
  logic        result_valid;
  logic [15:0] result_data;
  logic        result_ready;
  logic        busy;
  logic        done;
  logic        err;
  logic        err_clr;

  coproc_ctrl_fsm #(
    .MEM_RD_LAT     (LAT),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .dec_opcode   (dec_opcode),
    .dec_adrs     (dec_adrs),
    .dec_data     (dec_data),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mem_re       (mem_re),
    .mem_rdata    (mem_rdata),
    .alu_op       (alu_op),
    .alu_start    (alu_start),
    .alu_done     (alu_done),
    .result_valid (result_valid),
    .result_data  (result_data),
    .result_ready (result_ready),
    .busy         (busy),
    .done         (done),
    .err          (err),
    .err_clr      (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: data for a read appears LAT cycles after the mem_re cycle.
  logic [15:0] mem_arr [256];
  logic [LAT-1:0] re_pipe;
  logic [7:0]     adr_pipe [LAT];

  initial begin
    for (int i = 0; i < 256; i++) mem_arr[i] = {8'hA5, 8'(i)};
    mem_arr[3] = 16'h1234;
  end

  always @(posedge clk) begin
    if (!rst_n) begin
      re_pipe <= '0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) begin
        re_pipe[i]  <= re_pipe[i-1];
        adr_pipe[i] <= adr_pipe[i-1];
      end
      re_pipe[0]  <= mem_re;
      adr_pipe[0] <= mem_addr;
    end
  end

  assign mem_rdata = re_pipe[LAT-1] ? mem_arr[adr_pipe[LAT-1]] : 16'hDEAD;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  // Present an instruction and wait (bounded) for it to be accepted. On
  // return the bench sits just after the accepting edge, in cycle 1.
  task automatic issue(input logic [3:0] op, input logic [7:0] a, input logic [15:0] d,
                       output bit ok);
    instr_valid = 1'b1;
    dec_opcode  = op;
    dec_adrs    = a;
    dec_data    = d;
    ok = 1'b0;
    for (int n = 0; n < 8; n++) begin
      @(negedge clk);
      if (instr_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("accept", 32'(ok), 32'd1);
    if (ok) begin
      @(posedge clk);
      #1;
    end
    instr_valid = 1'b0;
    dec_opcode  = ~op;
    dec_adrs    = ~a;
    dec_data    = ~d;
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [7:0]  adrs;
    logic [15:0] data;
    int          kind;
    int          dly;     // LOAD: RHOLD cycles before ready; ALU: AWAIT cycles before done
    bit          early;   // LOAD: ready during RD/RWAIT; ALU: done during ASTART
    logic [15:0] exp_rd;
    int          lat;     // cycles from accept edge to the done cycle
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input int idx, input vec_t v);
    bit ok;
    logic [6:0] exp_ctl;
    issue(v.op, v.adrs, v.data, ok);
    if (!ok) return;
    for (int c = 1; c <= v.lat; c++) begin
      result_ready = (v.kind == K_LOAD) && ((c == 4 + v.dly) || (v.early && c <= 3));
      alu_done     = (v.kind == K_ALU) && ((c == 2 + v.dly) || (v.early && c == 1));
      @(negedge clk);
      // {instr_ready, busy, done, result_valid, alu_start, mem_re, mem_we}
      exp_ctl = {1'b0, 1'b1, (c == v.lat),
                 (v.kind == K_LOAD) && (c >= 4) && (c <= 4 + v.dly),
                 (v.kind == K_ALU) && (c == 1),
                 (v.kind == K_LOAD) && (c == 1),
                 (v.kind == K_STORE) && (c == 1)};
      chk($sformatf("v%0d_ctl_c%0d", idx, c),
          32'({instr_ready, busy, done, result_valid, alu_start, mem_re, mem_we}),
          32'(exp_ctl));
      if (v.kind == K_STORE && c == 1) begin
        chk($sformatf("v%0d_waddr", idx), 32'(mem_addr), 32'(v.adrs));
        chk($sformatf("v%0d_wdata", idx), 32'(mem_wdata), 32'(v.data));
      end
      if (v.kind == K_LOAD && c == 1)
        chk($sformatf("v%0d_raddr", idx), 32'(mem_addr), 32'(v.adrs));
      if (v.kind == K_LOAD && c == 4)
        chk($sformatf("v%0d_rdata", idx), 32'(result_data), 32'(v.exp_rd));
      if (v.kind == K_ALU && c == 1)
        chk($sformatf("v%0d_aluop", idx), 32'(alu_op), 32'(v.op));
      if (c < v.lat) begin
        @(posedge clk);
        #1;
      end
    end
    result_ready = 1'b0;
    alu_done     = 1'b0;
  endtask

`ifdef CTRL_TIMEOUT_EN
  // ALU op with no alu_done: AWAIT covers cycles 2..17, err shows in DONE (18).
  task automatic wd_run(input int clr_c, input logic exp_err);
    bit ok;
    issue(4'd5, 8'h00, 16'h0000, ok);
    if (!ok) return;
    for (int c = 1; c <= 18; c++) begin
      err_clr  = (c == clr_c);
      alu_done = 1'b0;
      @(negedge clk);
      if (c == 17) begin
        chk("wd_busy_c17", 32'({busy, done}), 32'b10);
        chk("wd_err_c17", 32'(err), 32'd0);
      end
      if (c == 18) begin
        chk("wd_done_c18", 32'(done), 32'd1);
        chk("wd_err_c18", 32'(err), 32'(exp_err));
      end
      if (c < 18) begin
        @(posedge clk);
        #1;
      end
    end
    err_clr = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("wd_idle", 32'({instr_ready, busy, err}), 32'({1'b1, 1'b0, exp_err}));
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "bench time limit");
  end

  initial begin
    bit ok;

    tbl[0] = '{4'd0,  8'h11, 16'h0001, K_NOP,   0, 1'b0, 16'h0000, 1};
    tbl[1] = '{4'd8,  8'h15, 16'hBEEF, K_STORE, 0, 1'b0, 16'h0000, 2};
    tbl[2] = '{4'd15, 8'hFF, 16'h0000, K_STORE, 0, 1'b0, 16'h0000, 2};
    tbl[3] = '{4'd1,  8'h03, 16'h0000, K_LOAD,  5, 1'b0, 16'h1234, 10};
    tbl[4] = '{4'd1,  8'h40, 16'h0000, K_LOAD,  0, 1'b1, 16'hA540, 5};
    tbl[5] = '{4'd3,  8'h00, 16'h0000, K_ALU,   6, 1'b1, 16'h0000, 9};
    tbl[6] = '{4'd2,  8'h00, 16'h0000, K_ALU,   0, 1'b0, 16'h0000, 3};
    tbl[7] = '{4'd7,  8'h00, 16'h0000, K_ALU,   2, 1'b0, 16'h0000, 5};

    rst_n        = 1'b0;
    instr_valid  = 1'b0;
    dec_opcode   = 4'h0;
    dec_adrs     = 8'h00;
    dec_data     = 16'h0000;
    alu_done     = 1'b0;
    result_ready = 1'b0;
    err_clr      = 1'b0;

    // Reset values after two reset cycles.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", 32'(instr_ready), 32'd1);
    chk("rst_ctl", 32'({busy, done, err, result_valid, mem_we, mem_re, alu_start}), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Back-to-back table vectors; each next instruction is offered in DONE.
    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

`ifdef CTRL_TIMEOUT_EN
    wd_run(0, 1'b1);
    @(posedge clk);
    #1;
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr = 1'b0;
    @(negedge clk);
    chk("err_clr", 32'(err), 32'd0);
    wd_run(17, 1'b0);
    wd_run(0, 1'b1);
`else
    // Without the watchdog AWAIT waits as long as needed.
    issue(4'd5, 8'h00, 16'h0000, ok);
    repeat (39) @(posedge clk);
    #1;
    @(negedge clk);
    chk("await_c40", 32'({busy, done, err}), 32'b100);
    @(posedge clk);
    #1;
    alu_done = 1'b1;
    @(posedge clk);
    #1;
    alu_done = 1'b0;
    @(negedge clk);
    chk("await_done", 32'({busy, done}), 32'b11);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("await_idle", 32'(instr_ready), 32'd1);
`endif

    // Reset in RHOLD: IDLE at the next edge, result and err dropped, no done.
    @(posedge clk);
    #1;
    issue(4'd1, 8'h03, 16'h0000, ok);
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rv", 32'(result_valid), 32'd1);
    @(posedge clk);
    #1;
    rst_n        = 1'b0;
    result_ready = 1'b1;
    @(posedge clk);
    #1;
    rst_n        = 1'b1;
    result_ready = 1'b0;
    @(negedge clk);
    chk("mid_rst_ctl", 32'({instr_ready, busy, done, result_valid, err}), 32'b10000);
    chk("mid_rst_data", 32'(result_data), 32'd0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("mid_rst_nodone", 32'({busy, done}), 32'b00);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
